// File: rtl/spi_slave_egress_mlane.sv
// SPI slave egress serialiser: pops bytes from a first-word-fall-through FIFO and shifts
// them out on 1, 2 or 4 MISO lanes, filling gaps with IDLE bytes and optionally framing bursts.
module spi_slave_egress_mlane #(
  parameter int unsigned LANES        = 2,
  parameter bit          MSB_FIRST    = 1'b0,
  parameter logic [7:0]  IDLE_VALUE   = 8'h3D,
  parameter bit          HEADER_EN    = 1'b0,
  parameter logic [7:0]  HEADER_VALUE = 8'hA0,
  parameter int unsigned MAX_BURST    = 0,
  parameter int unsigned COUNT_W      = 16
) (
  input  logic               spi_clk,
  input  logic               resn,
  input  logic               spi_csn,
  output logic [LANES-1:0]   spi_miso,
  input  logic               fifo_empty,
  input  logic [7:0]         fifo_data,
  output logic               fifo_shift_out,
  output logic               busy,
  output logic [COUNT_W-1:0] byte_count,
  output logic [1:0]         dbg_state
);

  localparam int unsigned BEATS   = 8 / LANES;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BURST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("spi_slave_egress_mlane: LANES must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_HEADER = 2'd2,
    ST_DATA   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           sr_q, sr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 pop_q, pop_d;
  logic                 busy_q, busy_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 clr_n;
  logic                 last_beat;
  logic                 take;
  logic [7:0]           sr_shift;

  // Chip-select high clears the frame exactly like reset does.
  assign clr_n     = resn & ~spi_csn;
  assign last_beat = (beat_q == LAST_BEAT);

  // Handshake: fifo_data is consumed only when fifo_empty is low on a last-beat edge;
  // fifo_shift_out is then high for the following cycle and the FIFO drops its head
  // on the next spi_clk edge that sees it high.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    count_d  = count_q;
    pop_d    = 1'b0;
    take     = 1'b0;
    sr_shift = MSB_FIRST ? (sr_q << LANES) : (sr_q >> LANES);

    if (state_q == ST_WAIT) begin
      state_d = ST_IDLE;
    end else if (!last_beat) begin
      beat_d = beat_q + BEAT_W'(1);
      sr_d   = sr_shift;
    end else begin
      beat_d = '0;
      sr_d   = IDLE_VALUE;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (HEADER_EN) begin
              sr_d    = HEADER_VALUE;
              state_d = ST_HEADER;
            end else begin
              take = 1'b1;
            end
          end
        end
        ST_HEADER: begin
          if (!fifo_empty) take = 1'b1;
          else state_d = ST_IDLE;
        end
        ST_DATA: begin
          if (!fifo_empty && (MAX_BURST == 0 || burst_q < BURST_CAP)) begin
            take = 1'b1;
          end else begin
            state_d = ST_IDLE;
            burst_d = '0;
          end
        end
        default: state_d = ST_WAIT;
      endcase

      if (take) begin
        sr_d    = fifo_data;
        pop_d   = 1'b1;
        state_d = ST_DATA;
        burst_d = (state_q == ST_DATA) ? burst_q + BURST_W'(1) : BURST_W'(1);
        if (count_q != '1) count_d = count_q + COUNT_W'(1);
      end
    end

    busy_d = (state_d == ST_HEADER) || (state_d == ST_DATA);
  end

  always_ff @(posedge spi_clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_WAIT;
      sr_q    <= IDLE_VALUE;
      beat_q  <= '0;
      burst_q <= '0;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    spi_miso = '0;
    if (!spi_csn) spi_miso = MSB_FIRST ? sr_q[7 -: LANES] : sr_q[LANES-1:0];
  end

  assign fifo_shift_out = pop_q;
  assign busy           = busy_q;
  assign byte_count     = count_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_spi_slave_egress_mlane.sv
// Bench for spi_slave_egress_mlane: four parameter variants driven from per-instance FIFO
// models and checked every cycle against a byte-slot reference model.
module tb_spi_slave_egress_mlane;

  localparam int A_NONE     = 0;
  localparam int A_CSN_RISE = 1;
  localparam int A_CSN_FALL = 2;
  localparam int A_RST_LO   = 3;
  localparam int A_RST_HI   = 4;
  localparam int M_IDLE     = 0;
  localparam int M_HDR      = 1;
  localparam int M_DATA     = 2;
  localparam logic [7:0] IDLE_V = 8'h3D;
  localparam logic [7:0] HDR_V  = 8'hA0;

  // variant table: u0 LANES=2 defaults, u1 LANES=4 MSB first, u2 header + burst cap 2,
  // u3 LANES=1 MSB first, header, burst cap 1, 3-bit counter
  int c_lanes [4] = '{2, 4, 2, 1};
  int c_msb   [4] = '{0, 1, 0, 1};
  int c_hdr   [4] = '{0, 0, 1, 1};
  int c_mb    [4] = '{0, 0, 2, 1};
  int c_cw    [4] = '{16, 16, 16, 3};

  logic        clk = 1'b0;
  logic        resn;
  logic        csn;
  logic [3:0]  empty_i;
  logic [7:0]  data_i [4];
  logic [3:0]  shift_o;
  logic [3:0]  busy_o;
  logic [1:0]  miso0;
  logic [3:0]  miso1;
  logic [1:0]  miso2;
  logic        miso3;
  logic [15:0] cnt0, cnt1, cnt2;
  logic [2:0]  cnt3;
  logic [1:0]  dbg0, dbg1, dbg2, dbg3;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state, one entry per instance
  int         m_cyc   [4];
  logic [7:0] m_cur   [4];
  int         m_mode  [4];
  int         m_burst [4];
  int         m_pops  [4];
  bit         m_pop   [4];

  logic [7:0] fmem [4][256];
  int         fhd [4];
  int         ftl [4];
  int         stall_pct;

  bit         cap_on = 1'b0;
  logic [7:0] cap_acc = '0;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] u2_seq [8] = '{8'h3D, 8'hA0, 8'h11, 8'h22, 8'h3D, 8'hA0, 8'h33, 8'h3D};

  always #5 clk = ~clk;

  spi_slave_egress_mlane #(.LANES(2)) u0 (
    .spi_clk(clk), .resn(resn), .spi_csn(csn), .spi_miso(miso0),
    .fifo_empty(empty_i[0]), .fifo_data(data_i[0]), .fifo_shift_out(shift_o[0]),
    .busy(busy_o[0]), .byte_count(cnt0), .dbg_state(dbg0));

  spi_slave_egress_mlane #(.LANES(4), .MSB_FIRST(1'b1)) u1 (
    .spi_clk(clk), .resn(resn), .spi_csn(csn), .spi_miso(miso1),
    .fifo_empty(empty_i[1]), .fifo_data(data_i[1]), .fifo_shift_out(shift_o[1]),
    .busy(busy_o[1]), .byte_count(cnt1), .dbg_state(dbg1));

  spi_slave_egress_mlane #(.LANES(2), .HEADER_EN(1'b1), .MAX_BURST(2)) u2 (
    .spi_clk(clk), .resn(resn), .spi_csn(csn), .spi_miso(miso2),
    .fifo_empty(empty_i[2]), .fifo_data(data_i[2]), .fifo_shift_out(shift_o[2]),
    .busy(busy_o[2]), .byte_count(cnt2), .dbg_state(dbg2));

  spi_slave_egress_mlane #(.LANES(1), .MSB_FIRST(1'b1), .HEADER_EN(1'b1), .MAX_BURST(1),
                           .COUNT_W(3)) u3 (
    .spi_clk(clk), .resn(resn), .spi_csn(csn), .spi_miso(miso3),
    .fifo_empty(empty_i[3]), .fifo_data(data_i[3]), .fifo_shift_out(shift_o[3]),
    .busy(busy_o[3]), .byte_count(cnt3), .dbg_state(dbg3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_miso(input int i);
    case (i)
      0: return 32'(miso0);
      1: return 32'(miso1);
      2: return 32'(miso2);
      default: return 32'(miso3);
    endcase
  endfunction

  function automatic logic [31:0] dut_cnt(input int i);
    case (i)
      0: return 32'(cnt0);
      1: return 32'(cnt1);
      2: return 32'(cnt2);
      default: return 32'(cnt3);
    endcase
  endfunction

  function automatic logic [31:0] dut_dbg(input int i);
    case (i)
      0: return 32'(dbg0);
      1: return 32'(dbg1);
      2: return 32'(dbg2);
      default: return 32'(dbg3);
    endcase
  endfunction

  // lane group 'beat' of byte b as it appears on the pins
  function automatic logic [31:0] lane_bits(input int i, input logic [7:0] b, input int beat);
    int l;
    int sh;
    l  = c_lanes[i];
    sh = (c_msb[i] != 0) ? 8 - l * (beat + 1) : l * beat;
    return (32'(b) >> sh) & ((32'd1 << l) - 32'd1);
  endfunction

  function automatic int cur_beat(input int i);
    return (m_cyc[i] == 0) ? 0 : (m_cyc[i] - 1) % (8 / c_lanes[i]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_cyc[i]   = 0;
      m_cur[i]   = IDLE_V;
      m_mode[i]  = M_IDLE;
      m_burst[i] = 0;
      m_pops[i]  = 0;
      m_pop[i]   = 1'b0;
    end
  endtask

  task automatic push(input int i, input logic [7:0] v);
    if (ftl[i] - fhd[i] < 250) begin
      fmem[i][ftl[i] % 256] = v;
      ftl[i]++;
    end
  endtask

  task automatic check_outputs(input string sfx);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_m;
      exp_m = csn ? 32'd0 : lane_bits(i, m_cur[i], cur_beat(i));
      check_eq($sformatf("u%0d_miso%s", i, sfx), dut_miso(i), exp_m);
      check_eq($sformatf("u%0d_pop%s", i, sfx), 32'(shift_o[i]), 32'(m_pop[i]));
      check_eq($sformatf("u%0d_busy%s", i, sfx), 32'(busy_o[i]), 32'(m_mode[i] != M_IDLE));
      check_eq($sformatf("u%0d_count%s", i, sfx), dut_cnt(i), 32'(m_pops[i]));
    end
  endtask

  task automatic check_wait_state();
    for (int i = 0; i < 4; i++) check_eq($sformatf("u%0d_state_clr", i), dut_dbg(i), 32'd0);
  endtask

  // byte-slot decision at the end of each byte time
  task automatic decide(input int i);
    bit avail;
    bit take;
    avail = !empty_i[i];
    take  = 1'b0;
    case (m_mode[i])
      M_IDLE: begin
        if (avail && c_hdr[i] != 0) begin
          m_cur[i]  = HDR_V;
          m_mode[i] = M_HDR;
        end else if (avail) begin
          take = 1'b1;
        end else begin
          m_cur[i] = IDLE_V;
        end
      end
      M_HDR: begin
        if (avail) take = 1'b1;
        else begin
          m_cur[i]  = IDLE_V;
          m_mode[i] = M_IDLE;
        end
      end
      default: begin
        if (avail && (c_mb[i] == 0 || m_burst[i] < c_mb[i])) take = 1'b1;
        else begin
          m_cur[i]   = IDLE_V;
          m_mode[i]  = M_IDLE;
          m_burst[i] = 0;
        end
      end
    endcase
    if (take) begin
      m_burst[i] = (m_mode[i] == M_DATA) ? m_burst[i] + 1 : 1;
      m_cur[i]   = data_i[i];
      m_mode[i]  = M_DATA;
      m_pop[i]   = 1'b1;
      if (m_pops[i] < (1 << c_cw[i]) - 1) m_pops[i]++;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int b;
      int beat;
      b = 8 / c_lanes[i];
      if (shift_o[i] === 1'b1 && fhd[i] != ftl[i]) fhd[i]++;
      if (csn || !resn) continue;
      m_pop[i] = 1'b0;
      if (m_cyc[i] == 0) begin
        m_cyc[i] = 1;
        continue;
      end
      beat = (m_cyc[i] - 1) % b;
      m_cyc[i]++;
      if (beat == b - 1) decide(i);
    end
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < 4; i++) begin
      bit stall;
      stall = ($urandom_range(0, 99) < stall_pct);
      if (fhd[i] == ftl[i] || stall) begin
        empty_i[i] = 1'b1;
        data_i[i]  = 8'($urandom);
      end else begin
        empty_i[i] = 1'b0;
        data_i[i]  = fmem[i][fhd[i] % 256];
      end
    end
  endtask

  task automatic capture_u2();
    int beat;
    if (csn || m_cyc[2] == 0) return;
    beat    = (m_cyc[2] - 1) % 4;
    cap_acc = cap_acc | (8'(miso2) << (2 * beat));
    if (beat == 3) begin
      got_q.push_back(cap_acc);
      cap_acc = '0;
    end
  endtask

  task automatic step(input int act);
    @(negedge clk);
    check_outputs("");
    if (cap_on) capture_u2();
    case (act)
      A_CSN_RISE: begin
        csn = 1'b1;
        #1;
        model_clear();
        check_outputs("_csn");
        check_wait_state();
      end
      A_CSN_FALL: begin
        csn = 1'b0;
        model_clear();
      end
      A_RST_LO: begin
        resn = 1'b0;
        #1;
        model_clear();
        check_outputs("_rst");
        check_wait_state();
      end
      A_RST_HI: resn = 1'b1;
      default: ;
    endcase
    drive_fifo();
    model_edge();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    csn       = 1'b1;
    resn      = 1'b0;
    empty_i   = '1;
    stall_pct = 0;
    for (int i = 0; i < 4; i++) begin
      data_i[i] = '0;
      fhd[i]    = 0;
      ftl[i]    = 0;
    end
    model_clear();

    // reset state, then directed frame from the test plan
    step(A_NONE);
    step(A_NONE);
    step(A_RST_HI);
    step(A_NONE);
    push(0, 8'hA5);
    push(1, 8'h5C);
    push(1, 8'h81);
    for (int i = 2; i < 4; i++) begin
      push(i, 8'h11);
      push(i, 8'h22);
      push(i, 8'h33);
    end
    cap_on = 1'b1;
    step(A_CSN_FALL);
    repeat (89) step(A_NONE);
    cap_on = 1'b0;
    check_eq("u0_count_dir", 32'(cnt0), 32'd1);
    check_eq("u1_count_dir", 32'(cnt1), 32'd2);
    check_eq("u2_count_dir", 32'(cnt2), 32'd3);
    check_eq("u3_count_dir", 32'(cnt3), 32'd3);
    foreach (u2_seq[k]) exp_q.push_back(u2_seq[k]);
    check_eq("u2_cap_len", 32'(got_q.size() >= exp_q.size()), 32'd1);
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check_eq($sformatf("u2_byte%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
    step(A_CSN_RISE);
    step(A_NONE);

    // chip select rises in the middle of u0's second data byte
    push(0, 8'h12);
    push(0, 8'h34);
    push(0, 8'h56);
    push(0, 8'h78);
    step(A_CSN_FALL);
    for (int n = 0; n < 40 && m_cyc[0] != 10; n++) step(A_NONE);
    check_eq("u0_mid_cycle", 32'(m_cyc[0]), 32'd10);
    check_eq("u0_count_pre", 32'(cnt0), 32'd2);
    step(A_CSN_RISE);
    step(A_NONE);
    step(A_CSN_FALL);
    repeat (30) step(A_NONE);
    step(A_CSN_RISE);

    // reset pulse while u2 is mid data burst
    push(2, 8'h44);
    push(2, 8'h55);
    push(2, 8'h66);
    step(A_CSN_FALL);
    for (int n = 0; n < 40 && m_mode[2] != M_DATA; n++) step(A_NONE);
    check_eq("u2_in_data", 32'(m_mode[2]), 32'(M_DATA));
    step(A_NONE);
    step(A_RST_LO);
    step(A_RST_HI);
    repeat (40) step(A_NONE);
    step(A_CSN_RISE);

    // randomized frames with FIFO stalls, refills, resets and frame aborts
    for (int f = 0; f < 12; f++) begin
      int len;
      stall_pct = $urandom_range(0, 40);
      for (int i = 0; i < 4; i++) begin
        int nb;
        nb = $urandom_range(0, 10);
        for (int k = 0; k < nb; k++) push(i, 8'($urandom));
      end
      step(A_CSN_FALL);
      len = $urandom_range(10, 160);
      for (int n = 0; n < len; n++) begin
        if ($urandom_range(0, 199) == 0) begin
          step(A_RST_LO);
          step(A_RST_HI);
        end else begin
          step(A_NONE);
        end
        if ($urandom_range(0, 99) < 15) push($urandom_range(0, 3), 8'($urandom));
      end
      step(A_CSN_RISE);
      step(A_NONE);
    end

    // long frame so the 3-bit counter of u3 saturates
    stall_pct = 0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 12; k++) push(i, 8'($urandom));
    step(A_CSN_FALL);
    repeat (320) step(A_NONE);
    check_eq("u3_count_sat", 32'(cnt3), 32'd7);
    step(A_CSN_RISE);
    step(A_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_egress_mlane.md
Name: spi_slave_egress_mlane

Overview:
- Parametrised successor of the 2-lane SPI slave egress serialiser.
- Pulls bytes from a first-word-fall-through 8-bit egress FIFO and shifts them out on 1, 2 or 4 MISO lanes, with selectable bit order.
- Inserts an IDLE byte when no data is available, and can optionally prepend a frame header byte and cap the burst length.
- Sits in the ASIC model SPI slave, between the egress FIFO and the pad-side MISO lanes, clocked by spi_clk.

Parameters:
- LANES, 2: MISO lanes; legal values 1, 2, 4. Beats per byte B = 8/LANES.
- MSB_FIRST, 0: 0 = LSB lanes first (previous-generation order); 1 = MSB lanes first.
- IDLE_VALUE, 8'h3D: byte sent when no data is available.
- HEADER_EN, 0: 1 = send HEADER_VALUE once before each data burst.
- HEADER_VALUE, 8'hA0: header byte.
- MAX_BURST, 0: maximum data bytes per burst before a forced IDLE byte; 0 = unlimited.
- COUNT_W, 16: width of the sent-byte counter.

Ports:
- spi_clk  in  1  SPI clock; all state updates on its rising edge.
- resn  in  1  asynchronous active-low reset.
- spi_csn  in  1  chip select, active low. High = asynchronous frame clear, same effect as reset.
- spi_miso  out  LANES  serial data out.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO head byte; valid while fifo_empty=0.
- fifo_shift_out  out  1  one-cycle pop strobe.
- busy  out  1  state is HEADER or DATA.
- byte_count  out  COUNT_W  data bytes popped since spi_csn fell; saturates at all-ones.

Behaviour:
- Async clear (resn=0 or spi_csn=1), applied immediately:
  - state=WAIT, shift register=IDLE_VALUE, beat counter=0, burst counter=0.
  - fifo_shift_out=0, byte_count=0, busy=0.
- spi_miso:
  - spi_csn=1 -> all zeros.
  - spi_csn=0, MSB_FIRST=0 -> sr[LANES-1:0]; MSB_FIRST=1 -> sr[7:8-LANES].
- Beat counter: 0..B-1; increments on every edge except in WAIT; wraps from B-1 to 0. "Last beat" means beat==B-1.
- Non-load edges: shift register shifts by LANES toward the output end, zero-filled.
- WAIT, first edge after spi_csn falls: go to IDLE, beat stays 0, shift register stays IDLE_VALUE. This is the CPOL=0 guard beat.
- Load decisions, taken on the last-beat edge (the shift register loads instead of shifting):
  - IDLE, FIFO non-empty, HEADER_EN=1: load HEADER_VALUE, go to HEADER, no pop.
  - IDLE, FIFO non-empty, HEADER_EN=0: load fifo_data, pulse pop, burst=1, go to DATA.
  - IDLE, FIFO empty: load IDLE_VALUE, stay in IDLE.
  - HEADER, FIFO non-empty: load fifo_data, pulse pop, burst=1, go to DATA.
  - HEADER, FIFO empty (external flush): load IDLE_VALUE, go to IDLE.
  - DATA, FIFO non-empty and (MAX_BURST=0 or burst<MAX_BURST): load fifo_data, pulse pop, burst+1, stay in DATA.
  - DATA, otherwise: load IDLE_VALUE, burst=0, go to IDLE. A capped burst therefore always has ≥1 IDLE byte before the next header/data.
- Pop strobe:
  - fifo_shift_out is registered on the load edge, high for exactly one spi_clk cycle (beat 0 of the new byte), then low.
  - At most one pop per byte time; never asserted when fifo_empty was 1 at the load edge.
- byte_count increments on each pop edge and saturates.
- burst counter width is clog2(MAX_BURST+1), minimum 1.
- Mid-byte spi_csn rise: output goes to 0 at once. A byte already popped but not fully shifted is lost; byte_count was already incremented for it. The next frame restarts in WAIT.
- fifo_empty changes at non-last beats are ignored.
- LANES=1 (B=8) and LANES=4 (B=2) use the same timing rules.
- Illegal LANES: elaboration error.

Test Plan:
- LANES=2, defaults, FIFO empty, spi_csn falls:
  - 1 WAIT beat, then spi_miso repeats 01,11,11,00 (0x3D, LSB first).
  - fifo_shift_out stays 0; byte_count=0.
- LANES=2, FIFO holds 0xA5 at CSN fall:
  - IDLE byte, then 01,01,10,10.
  - One pop pulse at beat 0 of that byte; byte_count=1; then IDLE resumes.
- LANES=4, MSB_FIRST=1, FIFO holds 0x5C, 0x81:
  - After the IDLE byte (3,D): 5,C,8,1, then IDLE.
  - Exactly two single-cycle pops.
- HEADER_EN=1, MAX_BURST=2, FIFO holds 3 bytes 0x11, 0x22, 0x33:
  - Byte sequence IDLE, A0, 11, 22, 3D, A0, 33, 3D.
  - busy high during header/data bytes; byte_count=3.
- spi_csn rises mid-way through the second data byte:
  - spi_miso=0 and fifo_shift_out=0 immediately.
  - Next CSN fall restarts with WAIT + IDLE; byte_count restarts at 0.
- resn pulse low during DATA:
  - All outputs return to reset values asynchronously.
  - No further pops until a new last-beat edge with FIFO non-empty.
